clk_div_prog: RTL

- Runtime-programmable integer clock divider; successor to the fixed divide-by-24 block.
- Produces a single-clock-domain divided strobe clock `g_clk` with near-50% duty for any divisor N ≥ 2.
- Also produces a one-cycle period tick and an observable phase counter.
- Divisor changes are glitch-free: applied only at a period boundary. Used as the timing source for downstream enable-gated logic.

---
 rtl/clk_div_prog.sv | 132 +++++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider.
// Produces a near-50% divided clock, a one-cycle period tick and an
// observable phase counter. A new divisor is held as pending and only
// takes effect at a period boundary, so the divided clock never glitches.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic [WIDTH-1:0] count,
  output logic             g_clk,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             pending,
  output logic             err
);

  localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DIV_MIN   = WIDTH'(32'd2);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(32'd1);
  localparam logic [WIDTH-1:0] ZERO      = WIDTH'(32'd0);

  // Length of the low phase for divisor n: floor(n/2).
  function automatic logic [WIDTH-1:0] low_len(input logic [WIDTH-1:0] n);
    low_len = n >> 1;
  endfunction

  // Registered state
  logic [WIDTH-1:0] count_r;
  logic             g_clk_r;
  logic             tick_r;
  logic [WIDTH-1:0] div_active_r;
  logic             pending_r;
  logic [WIDTH-1:0] pend_div_r;
  logic             err_r;

  // Next-state signals
  logic             wrap_s;
  logic             load_ok_s;
  logic             load_bad_s;
  logic [WIDTH-1:0] count_nx_s;
  logic [WIDTH-1:0] div_nx_s;
  logic             g_clk_nx_s;
  logic             pending_nx_s;
  logic [WIDTH-1:0] pend_div_nx_s;

  // Classify the current cycle: period wrap and divisor request validity.
  always_comb begin
    wrap_s     = en & (count_r == (div_active_r - ONE));
    load_ok_s  = div_load & (div_in >= DIV_MIN);
    load_bad_s = div_load & (div_in < DIV_MIN);
  end

  // Next phase count: hold when disabled, restart at the wrap, else advance.
  always_comb begin
    count_nx_s = count_r;
    if (!en) begin
      count_nx_s = count_r;
    end else if (wrap_s) begin
      count_nx_s = ZERO;
    end else begin
      count_nx_s = count_r + ONE;
    end
  end

  // Next active divisor: a pending value is swapped in only on a wrap.
  always_comb begin
    div_nx_s = div_active_r;
    if (wrap_s && pending_r) begin
      div_nx_s = pend_div_r;
    end else begin
      div_nx_s = div_active_r;
    end
  end

  // Divided clock is derived from the next count and next divisor so the
  // registered output always matches the count it is shown with.
  always_comb begin
    g_clk_nx_s = (count_nx_s >= low_len(div_nx_s));
  end

  // Pending divisor bookkeeping: a valid load always wins (last one wins,
  // and a load in the wrap cycle queues for the following boundary);
  // otherwise a wrap consumes the pending value.
  always_comb begin
    pending_nx_s  = pending_r;
    pend_div_nx_s = pend_div_r;
    if (load_ok_s) begin
      pending_nx_s  = 1'b1;
      pend_div_nx_s = div_in;
    end else if (wrap_s && pending_r) begin
      pending_nx_s  = 1'b0;
      pend_div_nx_s = pend_div_r;
    end else begin
      pending_nx_s  = pending_r;
      pend_div_nx_s = pend_div_r;
    end
  end

  // State registers with synchronous reset to the default divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r      <= ZERO;
      g_clk_r      <= 1'b0;
      tick_r       <= 1'b0;
      div_active_r <= DIV_RESET;
      pending_r    <= 1'b0;
      pend_div_r   <= ZERO;
      err_r        <= 1'b0;
    end else begin
      count_r      <= count_nx_s;
      g_clk_r      <= g_clk_nx_s;
      tick_r       <= wrap_s;
      div_active_r <= div_nx_s;
      pending_r    <= pending_nx_s;
      pend_div_r   <= pend_div_nx_s;
      err_r        <= err_r | load_bad_s;
    end
  end

  assign count      = count_r;
  assign g_clk      = g_clk_r;
  assign tick       = tick_r;
  assign div_active = div_active_r;
  assign pending    = pending_r;
  assign err        = err_r;

endmodule
